mem_bus_ctrl: RTL and testbench

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

---
 rtl/mem_bus_ctrl_pkg.sv | 25 ++
 rtl/mem_bus_ctrl_mem_array.sv | 29 ++
 rtl/mem_bus_ctrl.sv | 129 ++++++++++++
 tb/tb_mem_bus_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the memory bus controller: state encodings,
// direction constants, default sizing and the address range helper.
package mem_bus_defs;

  localparam int DEF_WAIT_CYCLES = 2;
  localparam int DEF_DEPTH       = 1024;
  localparam int DEF_AW          = 10;

  localparam logic DIR_RD = 1'b1;
  localparam logic DIR_WR = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_DONE    = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

  // True when a 16-bit word address falls inside the implemented array.
  function automatic logic addr_in_range(input logic [15:0] addr, input int depth);
    return ({16'h0000, addr} < 32'(depth));
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_mem_array.sv
// Single-port synchronous RAM, DEPTH x 16, registered read, no reset.
// Contents survive controller reset on purpose.
module mem_array
  import mem_bus_defs::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [15:0]   wdata_i,
  output logic [15:0]   rdata_o
);

  logic [15:0] mem_q [DEPTH];

  // Write commit and registered read share the single address port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU-facing memory bus controller: samples a request in IDLE, inserts
// WAIT_CYCLES wait states, performs one array access, reports completion
// for one cycle and then waits for the request to be withdrawn.
module mem_bus_ctrl
  import mem_bus_defs::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int AW          = DEF_AW
) (
  input  logic        clk,
  input  logic        MEM_rst_n,
  input  logic [15:0] MAB,
  inout  wire  [15:0] MDB,
  input  logic        read_write,
  input  logic        initiate_op,
  output logic        op_complete,
  output logic        addr_err
);

  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        dir_q;
  logic        op_complete_q;
  logic        addr_err_q;
  logic        mdb_oe_q;

  logic        in_range_s;
  logic        we_s;
  logic        re_s;
  logic [15:0] rdata_s;
  logic [15:0] drive_s;

  // Access strobes derive from the latched request, never from live inputs.
  always_comb begin
    in_range_s = addr_in_range(addr_q, DEPTH);
    we_s       = (state_q == ST_ACCESS) && (dir_q == DIR_WR) && in_range_s;
    re_s       = (state_q == ST_ACCESS) && (dir_q == DIR_RD) && in_range_s;
  end

  // Request sequencing with registered handshake and bus-enable outputs.
  always_ff @(posedge clk or negedge MEM_rst_n) begin
    if (!MEM_rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 4'd0;
      addr_q        <= 16'h0000;
      wdata_q       <= 16'h0000;
      dir_q         <= DIR_WR;
      op_complete_q <= 1'b0;
      addr_err_q    <= 1'b0;
      mdb_oe_q      <= 1'b0;
    end else begin
      op_complete_q <= 1'b0;
      addr_err_q    <= 1'b0;
      mdb_oe_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (initiate_op) begin
            addr_q <= MAB;
            dir_q  <= read_write;
            if (read_write == DIR_WR) begin
              wdata_q <= MDB;
            end
            if (WAIT_CYCLES > 0) begin
              state_q <= ST_WAIT;
              cnt_q   <= WAIT_LOAD;
            end else begin
              state_q <= ST_ACCESS;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= ST_ACCESS;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_ACCESS: begin
          state_q       <= ST_DONE;
          op_complete_q <= 1'b1;
          addr_err_q    <= !in_range_s;
          mdb_oe_q      <= (dir_q == DIR_RD);
        end
        ST_DONE: begin
          state_q <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (!initiate_op) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  mem_array #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem_array (
    .clk    (clk),
    .we_i   (we_s),
    .re_i   (re_s),
    .addr_i (addr_q[AW-1:0]),
    .wdata_i(wdata_q),
    .rdata_o(rdata_s)
  );

  // Out-of-range reads return zero instead of whatever the RAM last held.
  always_comb begin
    if (addr_err_q) begin
      drive_s = 16'h0000;
    end else begin
      drive_s = rdata_s;
    end
  end

  assign MDB         = mdb_oe_q ? drive_s : 16'hzzzz;
  assign op_complete = op_complete_q;
  assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: one instance with two wait states and
// one with none. The data buses have pull-ups so an undriven bus reads FFFF.
module tb_mem_bus_ctrl;
  import mem_bus_defs::*;

  logic        clk;
  logic        rst_n;
  logic [15:0] mab, mab0;
  logic        rw, rw0;
  logic        init, init0;
  logic        den, den0;
  logic [15:0] dd, dd0;
  logic        opc, opc0, aerr, aerr0;
  wire  [15:0] mdb, mdb0;

  int pass_cnt;
  int total_cnt;

  assign mdb  = den  ? dd  : 16'hzzzz;
  assign mdb0 = den0 ? dd0 : 16'hzzzz;

  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (mdb[g]);
    pullup (mdb0[g]);
  end

  mem_bus_ctrl #(.WAIT_CYCLES(2), .DEPTH(1024), .AW(10)) dut (
    .clk(clk), .MEM_rst_n(rst_n), .MAB(mab), .MDB(mdb), .read_write(rw),
    .initiate_op(init), .op_complete(opc), .addr_err(aerr)
  );

  mem_bus_ctrl #(.WAIT_CYCLES(0), .DEPTH(1024), .AW(10)) dut0 (
    .clk(clk), .MEM_rst_n(rst_n), .MAB(mab0), .MDB(mdb0), .read_write(rw0),
    .initiate_op(init0), .op_complete(opc0), .addr_err(aerr0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req(input bit which, input logic iop, input logic r, input logic [15:0] a,
                         input logic de, input logic [15:0] d);
    if (which) begin
      init0 = iop; rw0 = r; mab0 = a; den0 = de; dd0 = d;
    end else begin
      init = iop; rw = r; mab = a; den = de; dd = d;
    end
  endtask

  // Runs one request; starts and ends at posedge+1 with the DUT in IDLE.
  task automatic do_op(input bit which, input logic is_rd, input logic [15:0] addr,
                       input logic [15:0] wd, input bit disturb, input bit drop_early,
                       output logic [15:0] rd, output int lat, output int opc_len,
                       output int err_len, output logic [15:0] rel_bus);
    logic o, e;
    logic [15:0] b;
    lat = -1; opc_len = 0; err_len = 0; rd = 16'h0000; rel_bus = 16'h0000;
    set_req(which, 1'b1, is_rd, addr, !is_rd, wd);
    @(posedge clk); #1;
    if (disturb) set_req(which, !drop_early, !is_rd, addr ^ 16'h0001, 1'b1, ~wd);
    else set_req(which, !drop_early, is_rd, addr, 1'b0, wd);
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) begin den = 1'b0; den0 = 1'b0; end
      @(posedge clk); #1;
      o = which ? opc0 : opc;
      e = which ? aerr0 : aerr;
      b = which ? mdb0 : mdb;
      if (o) begin
        if (lat < 0) begin lat = k + 1; rd = b; end
        opc_len++;
      end
      if (e) err_len++;
      if (lat >= 0 && !o) begin rel_bus = b; break; end
    end
    init = 1'b0; init0 = 1'b0; den = 1'b0; den0 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #2;
    total_cnt++; if (opc !== 1'b0) $display("FAIL rst_opc: got %b want 0", opc); else pass_cnt++;
    total_cnt++; if (aerr !== 1'b0) $display("FAIL rst_aerr: got %b want 0", aerr); else pass_cnt++;
    total_cnt++; if (mdb !== 16'hFFFF) $display("FAIL rst_mdb_z: got %h want FFFF(pulled)", mdb); else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_write_read;
    logic [15:0] rd, rb; int lat, ol, el;
    do_op(0, DIR_WR, 16'h0010, 16'hA5C3, 0, 0, rd, lat, ol, el, rb);
    total_cnt++; if (lat !== 4) $display("FAIL wr_lat: got %0d want 4", lat); else pass_cnt++;
    total_cnt++; if (ol !== 1) $display("FAIL wr_opc_len: got %0d want 1", ol); else pass_cnt++;
    total_cnt++; if (el !== 0) $display("FAIL wr_err: got %0d want 0", el); else pass_cnt++;
    total_cnt++; if (rd !== 16'hFFFF) $display("FAIL wr_mdb_z: got %h want FFFF", rd); else pass_cnt++;
    do_op(0, DIR_RD, 16'h0010, 16'h0000, 0, 0, rd, lat, ol, el, rb);
    total_cnt++; if (lat !== 4) $display("FAIL rd_lat: got %0d want 4", lat); else pass_cnt++;
    total_cnt++; if (rd !== 16'hA5C3) $display("FAIL rd_data: got %h want A5C3", rd); else pass_cnt++;
    total_cnt++; if (ol !== 1) $display("FAIL rd_opc_len: got %0d want 1", ol); else pass_cnt++;
    total_cnt++; if (rb !== 16'hFFFF) $display("FAIL rd_release_z: got %h want FFFF", rb); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [15:0] rd, rb; int lat, ol, el;
    do_op(0, DIR_WR, 16'h0001, 16'h5A5A, 0, 0, rd, lat, ol, el, rb);
    do_op(0, DIR_WR, 16'h03FF, 16'h0F0F, 0, 0, rd, lat, ol, el, rb);
    total_cnt++; if (lat !== 4) $display("FAIL b2b_wr_lat: got %0d want 4", lat); else pass_cnt++;
    do_op(0, DIR_RD, 16'h0001, 16'h0000, 0, 0, rd, lat, ol, el, rb);
    total_cnt++; if (rd !== 16'h5A5A) $display("FAIL b2b_rd1: got %h want 5A5A", rd); else pass_cnt++;
    do_op(0, DIR_RD, 16'h03FF, 16'h0000, 0, 0, rd, lat, ol, el, rb);
    total_cnt++; if (rd !== 16'h0F0F) $display("FAIL b2b_rd2: got %h want 0F0F", rd); else pass_cnt++;
    total_cnt++; if (lat !== 4) $display("FAIL b2b_rd_lat: got %0d want 4", lat); else pass_cnt++;
  endtask

  task automatic test_addr_err;
    logic [15:0] rd, rb; int lat, ol, el;
    do_op(0, DIR_WR, 16'h0000, 16'h1111, 0, 0, rd, lat, ol, el, rb);
    do_op(0, DIR_RD, 16'h0400, 16'h0000, 0, 0, rd, lat, ol, el, rb);
    total_cnt++; if (rd !== 16'h0000) $display("FAIL oor_rd_data: got %h want 0000", rd); else pass_cnt++;
    total_cnt++; if (el !== 1) $display("FAIL oor_rd_err_len: got %0d want 1", el); else pass_cnt++;
    do_op(0, DIR_WR, 16'h0400, 16'hDEAD, 0, 0, rd, lat, ol, el, rb);
    total_cnt++; if (el !== 1) $display("FAIL oor_wr_err_len: got %0d want 1", el); else pass_cnt++;
    do_op(0, DIR_RD, 16'h0000, 16'h0000, 0, 0, rd, lat, ol, el, rb);
    total_cnt++; if (rd !== 16'h1111) $display("FAIL oor_alias: got %h want 1111", rd); else pass_cnt++;
    total_cnt++; if (el !== 0) $display("FAIL inrange_err: got %0d want 0", el); else pass_cnt++;
    do_op(0, DIR_RD, 16'hFFFF, 16'h0000, 0, 0, rd, lat, ol, el, rb);
    total_cnt++; if (el !== 1) $display("FAIL oor_ffff_err: got %0d want 1", el); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    logic [15:0] rd, rb; int lat, ol, el;
    do_op(0, DIR_WR, 16'h0020, 16'h7777, 0, 0, rd, lat, ol, el, rb);
    set_req(0, 1'b1, DIR_WR, 16'h0020, 1'b1, 16'hBEEF);
    @(posedge clk); #1;
    den = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; init = 1'b0;
    #1;
    total_cnt++; if (opc !== 1'b0) $display("FAIL mid_rst_opc: got %b want 0", opc); else pass_cnt++;
    total_cnt++; if (mdb !== 16'hFFFF) $display("FAIL mid_rst_mdb: got %h want FFFF", mdb); else pass_cnt++;
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(0, DIR_RD, 16'h0020, 16'h0000, 0, 0, rd, lat, ol, el, rb);
    total_cnt++; if (rd !== 16'h7777) $display("FAIL mid_rst_keep: got %h want 7777", rd); else pass_cnt++;
  endtask

  task automatic test_hold;
    logic [15:0] rd, rb; int lat, ol, el; bit seen; int extra; int drv;
    seen = 0; extra = 0; drv = 0;
    set_req(0, 1'b1, DIR_WR, 16'h0030, 1'b1, 16'h3030);
    @(posedge clk); #1;
    den = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (opc) begin seen = 1; break; end
    end
    rw = DIR_RD;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (opc) extra++;
      if (mdb !== 16'hFFFF) drv++;
    end
    total_cnt++; if (seen !== 1'b1) $display("FAIL hold_first_opc: got %b want 1", seen); else pass_cnt++;
    total_cnt++; if (extra !== 0) $display("FAIL hold_no_second: got %0d want 0", extra); else pass_cnt++;
    total_cnt++; if (drv !== 0) $display("FAIL hold_mdb_z: got %0d want 0", drv); else pass_cnt++;
    init = 1'b0;
    @(posedge clk); #1;
    do_op(0, DIR_RD, 16'h0030, 16'h0000, 0, 0, rd, lat, ol, el, rb);
    total_cnt++; if (rd !== 16'h3030) $display("FAIL hold_rd: got %h want 3030", rd); else pass_cnt++;
    total_cnt++; if (lat !== 4) $display("FAIL hold_rd_lat: got %0d want 4", lat); else pass_cnt++;
  endtask

  task automatic test_sampled_inputs;
    logic [15:0] rd, rb; int lat, ol, el;
    do_op(0, DIR_WR, 16'h0041, 16'h4141, 0, 0, rd, lat, ol, el, rb);
    do_op(0, DIR_WR, 16'h0040, 16'hC0DE, 1, 0, rd, lat, ol, el, rb);
    total_cnt++; if (lat !== 4) $display("FAIL dist_lat: got %0d want 4", lat); else pass_cnt++;
    do_op(0, DIR_RD, 16'h0040, 16'h0000, 0, 0, rd, lat, ol, el, rb);
    total_cnt++; if (rd !== 16'hC0DE) $display("FAIL dist_addr_data: got %h want C0DE", rd); else pass_cnt++;
    do_op(0, DIR_RD, 16'h0041, 16'h0000, 0, 0, rd, lat, ol, el, rb);
    total_cnt++; if (rd !== 16'h4141) $display("FAIL dist_neighbour: got %h want 4141", rd); else pass_cnt++;
  endtask

  task automatic test_early_drop;
    logic [15:0] rd, rb; int lat, ol, el;
    do_op(0, DIR_RD, 16'h0010, 16'h0000, 0, 1, rd, lat, ol, el, rb);
    total_cnt++; if (lat !== 4) $display("FAIL drop_lat: got %0d want 4", lat); else pass_cnt++;
    total_cnt++; if (rd !== 16'hA5C3) $display("FAIL drop_data: got %h want A5C3", rd); else pass_cnt++;
    do_op(0, DIR_RD, 16'h0001, 16'h0000, 0, 0, rd, lat, ol, el, rb);
    total_cnt++; if (rd !== 16'h5A5A) $display("FAIL drop_next: got %h want 5A5A", rd); else pass_cnt++;
  endtask

  task automatic test_wait0;
    logic [15:0] rd, rb; int lat, ol, el;
    do_op(1, DIR_WR, 16'h03FF, 16'h1234, 0, 0, rd, lat, ol, el, rb);
    total_cnt++; if (lat !== 2) $display("FAIL w0_wr_lat: got %0d want 2", lat); else pass_cnt++;
    do_op(1, DIR_RD, 16'h03FF, 16'h0000, 0, 0, rd, lat, ol, el, rb);
    total_cnt++; if (lat !== 2) $display("FAIL w0_rd_lat: got %0d want 2", lat); else pass_cnt++;
    total_cnt++; if (rd !== 16'h1234) $display("FAIL w0_rd_data: got %h want 1234", rd); else pass_cnt++;
    total_cnt++; if (ol !== 1) $display("FAIL w0_opc_len: got %0d want 1", ol); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    rst_n = 1'b0;
    init = 1'b0; rw = DIR_WR; mab = 16'h0000; den = 1'b0; dd = 16'h0000;
    init0 = 1'b0; rw0 = DIR_WR; mab0 = 16'h0000; den0 = 1'b0; dd0 = 16'h0000;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_addr_err();
    test_reset_mid();
    test_hold();
    test_sampled_inputs();
    test_early_drop();
    test_wait0();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
